// File: rtl/float_multiplier_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// float_multiplier_pipe_if : operand/result handshake bundle for the multiplier
// Revision: 1.0
// ----------------------------------------------------------------------------
interface float_multiplier_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic        as;
  logic [7:0]  ae;
  logic [23:0] am;
  logic        bs;
  logic [7:0]  be;
  logic [23:0] bm;
  logic        out_valid;
  logic        out_ready;
  logic        ps;
  logic [7:0]  pe;
  logic [23:0] pm;
  logic        flag_clr;
  logic        ovf;
  logic        unf;

  modport slave (
    input  in_valid, as, ae, am, bs, be, bm, out_ready, flag_clr,
    output in_ready, out_valid, ps, pe, pm, ovf, unf
  );

  modport master (
    output in_valid, as, ae, am, bs, be, bm, out_ready, flag_clr,
    input  in_ready, out_valid, ps, pe, pm, ovf, unf
  );
endinterface
`default_nettype wire

// File: rtl/float_multiplier_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// float_multiplier_pipe : 3-stage unpacked single-precision multiplier, RNE,
//                         saturating overflow, flush-to-zero underflow
// Revision: 1.0
// ----------------------------------------------------------------------------
module float_multiplier_pipe #(
  parameter int BIAS = 127,
  parameter int EMAX = 254
) (
  input  logic                    clk,
  input  logic                    rst,
  float_multiplier_pipe_if.slave  bus
);

  localparam logic signed [9:0] c_bias = 10'(BIAS);
  localparam logic signed [9:0] c_emax = 10'(EMAX);
  localparam logic signed [9:0] c_one  = 10'sd1;

  logic adv;

  // Stage 1: sign, zero, raw exponent and full product
  logic               v1_q;
  logic               s1_sign_q, s1_sign_d;
  logic               s1_zero_q, s1_zero_d;
  logic signed [9:0]  s1_exp_q,  s1_exp_d;
  logic [47:0]        s1_prod_q, s1_prod_d;

  // Stage 2: normalised and rounded
  logic               v2_q;
  logic               s2_sign_q;
  logic               s2_zero_q;
  logic signed [9:0]  s2_exp_q,  s2_exp_d;
  logic [23:0]        s2_mant_q, s2_mant_d;

  // Stage 3: output register and sticky flags
  logic               out_valid_q;
  logic               ps_q, ps_d;
  logic [7:0]         pe_q, pe_d;
  logic [23:0]        pm_q, pm_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               w_ovf, w_unf;

  logic [23:0]        nrm_mant;
  logic               nrm_g, nrm_r, nrm_s;
  logic signed [9:0]  nrm_exp;
  logic               rnd_inc;
  logic [24:0]        rnd_sum;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    s1_sign_d = bus.as ^ bus.bs;
    s1_zero_d = (bus.am == 24'd0) || (bus.bm == 24'd0);
    s1_exp_d  = $signed({2'b00, bus.ae}) + $signed({2'b00, bus.be}) - c_bias;
    s1_prod_d = bus.am * bus.bm;
  end

  always_comb begin
    if (s1_prod_q[47]) begin
      nrm_mant = s1_prod_q[47:24];
      nrm_g    = s1_prod_q[23];
      nrm_r    = s1_prod_q[22];
      nrm_s    = |s1_prod_q[21:0];
      nrm_exp  = s1_exp_q + c_one;
    end else begin
      nrm_mant = s1_prod_q[46:23];
      nrm_g    = s1_prod_q[22];
      nrm_r    = s1_prod_q[21];
      nrm_s    = |s1_prod_q[20:0];
      nrm_exp  = s1_exp_q;
    end
    rnd_inc = nrm_g & (nrm_r | nrm_s | nrm_mant[0]);
    rnd_sum = {1'b0, nrm_mant} + {24'd0, rnd_inc};
    // Rounding 0xFFFFFF up lands exactly on the next binade
    if (rnd_sum[24]) begin
      s2_mant_d = 24'h800000;
      s2_exp_d  = nrm_exp + c_one;
    end else begin
      s2_mant_d = rnd_sum[23:0];
      s2_exp_d  = nrm_exp;
    end
  end

  always_comb begin
    w_unf = !s2_zero_q && (s2_exp_q < c_one);
    w_ovf = !s2_zero_q && (s2_exp_q > c_emax);
    if (s2_zero_q || w_unf) begin
      ps_d = 1'b0;
      pe_d = 8'd0;
      pm_d = 24'd0;
    end else if (w_ovf) begin
      ps_d = s2_sign_q;
      pe_d = c_emax[7:0];
      pm_d = 24'hFFFFFF;
    end else begin
      ps_d = s2_sign_q;
      pe_d = s2_exp_q[7:0];
      pm_d = s2_mant_q;
    end
    // A flag raised this cycle takes precedence over a simultaneous clear
    ovf_d = (ovf_q & ~bus.flag_clr) | (adv & v2_q & w_ovf);
    unf_d = (unf_q & ~bus.flag_clr) | (adv & v2_q & w_unf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_prod_q   <= '0;
      v2_q        <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_mant_q   <= '0;
      out_valid_q <= 1'b0;
      ps_q        <= 1'b0;
      pe_q        <= '0;
      pm_q        <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      if (adv) begin
        v1_q        <= bus.in_valid;
        s1_sign_q   <= s1_sign_d;
        s1_zero_q   <= s1_zero_d;
        s1_exp_q    <= s1_exp_d;
        s1_prod_q   <= s1_prod_d;
        v2_q        <= v1_q;
        s2_sign_q   <= s1_sign_q;
        s2_zero_q   <= s1_zero_q;
        s2_exp_q    <= s2_exp_d;
        s2_mant_q   <= s2_mant_d;
        out_valid_q <= v2_q;
        // Bubbles leave the last result visible on the data outputs
        if (v2_q) begin
          ps_q <= ps_d;
          pe_q <= pe_d;
          pm_q <= pm_d;
        end
      end
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.ps        = ps_q;
  assign bus.pe        = pe_q;
  assign bus.pm        = pm_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_float_multiplier_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_float_multiplier_pipe : directed-vector bench for float_multiplier_pipe
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_float_multiplier_pipe;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  float_multiplier_pipe_if bus ();

  float_multiplier_pipe #(.BIAS(127), .EMAX(254)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operand pair with the consumer always ready; returns the
  // result and the number of edges from acceptance to out_valid (-1 = timeout).
  task automatic run_op(input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                        input logic sb, input logic [7:0] eb, input logic [23:0] mb,
                        output logic [32:0] res, output int lat);
    lat = -1;
    res = '0;
    @(negedge clk);
    bus.as = sa; bus.ae = ea; bus.am = ma;
    bus.bs = sb; bus.be = eb; bus.bm = mb;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin
        res = {bus.ps, bus.pe, bus.pm};
        lat = k;
        break;
      end
    end
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    bus.flag_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.flag_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flag_clr = 1'b0;
    bus.as = 1'b0; bus.ae = '0; bus.am = '0;
    bus.bs = 1'b0; bus.be = '0; bus.bm = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if ({bus.ps, bus.pe, bus.pm} !== 33'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", {bus.ps, bus.pe, bus.pm}); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    n_cmp++; if (bus.unf !== 1'b0) begin n_fail++; $display("FAIL reset_unf: got %b want 0", bus.unf); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_simple;
    logic [32:0] r; int lat;
    run_op(1'b0, 8'd127, 24'hC00000, 1'b0, 8'd128, 24'h800000, r, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL simple_latency: got %0d want 3", lat); end
    n_cmp++; if (r !== {1'b0, 8'd128, 24'hC00000}) begin n_fail++; $display("FAIL simple_result: got %h want %h", r, {1'b0, 8'd128, 24'hC00000}); end
  endtask

  task automatic test_normalise;
    logic [32:0] r; int lat;
    run_op(1'b1, 8'd127, 24'hC00000, 1'b1, 8'd127, 24'hC00000, r, lat);
    n_cmp++; if (r !== {1'b0, 8'd128, 24'h900000}) begin n_fail++; $display("FAIL normalise: got %h want %h", r, {1'b0, 8'd128, 24'h900000}); end
    run_op(1'b1, 8'd100, 24'hC00000, 1'b0, 8'd130, 24'hA00000, r, lat);
    n_cmp++; if (r !== {1'b1, 8'd103, 24'hF00000}) begin n_fail++; $display("FAIL normalise_sign: got %h want %h", r, {1'b1, 8'd103, 24'hF00000}); end
  endtask

  task automatic test_round_even;
    logic [32:0] r; int lat;
    run_op(1'b0, 8'd127, 24'h800001, 1'b0, 8'd127, 24'hC00000, r, lat);
    n_cmp++; if (r !== {1'b0, 8'd127, 24'hC00002}) begin n_fail++; $display("FAIL round_tie_odd: got %h want %h", r, {1'b0, 8'd127, 24'hC00002}); end
    // Tie with even lsb stays put: 0x800003*0xC00000 -> mant C00004, G=1 R=S=0
    run_op(1'b0, 8'd127, 24'h800003, 1'b0, 8'd127, 24'hC00000, r, lat);
    n_cmp++; if (r !== {1'b0, 8'd127, 24'hC00004}) begin n_fail++; $display("FAIL round_tie_even: got %h want %h", r, {1'b0, 8'd127, 24'hC00004}); end
  endtask

  task automatic test_zero_underflow;
    logic [32:0] r; int lat;
    run_op(1'b1, 8'd200, 24'h000000, 1'b0, 8'd130, 24'hC00000, r, lat);
    n_cmp++; if (r !== 33'd0) begin n_fail++; $display("FAIL zero_result: got %h want 0", r); end
    n_cmp++; if ({bus.ovf, bus.unf} !== 2'b00) begin n_fail++; $display("FAIL zero_flags: got %b want 00", {bus.ovf, bus.unf}); end
    run_op(1'b0, 8'd1, 24'h800000, 1'b0, 8'd1, 24'h800000, r, lat);
    n_cmp++; if (r !== 33'd0) begin n_fail++; $display("FAIL underflow_result: got %h want 0", r); end
    n_cmp++; if (bus.unf !== 1'b1) begin n_fail++; $display("FAIL underflow_flag: got %b want 1", bus.unf); end
    pulse_clr();
    n_cmp++; if (bus.unf !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b want 0", bus.unf); end
    run_op(1'b1, 8'd1, 24'h800000, 1'b0, 8'd127, 24'h800000, r, lat);
    n_cmp++; if (r !== {1'b1, 8'd1, 24'h800000}) begin n_fail++; $display("FAIL exp_one_result: got %h want %h", r, {1'b1, 8'd1, 24'h800000}); end
    n_cmp++; if (bus.unf !== 1'b0) begin n_fail++; $display("FAIL exp_one_flag: got %b want 0", bus.unf); end
    run_op(1'b1, 8'd0, 24'h800000, 1'b0, 8'd127, 24'h800000, r, lat);
    n_cmp++; if ({r, bus.unf} !== {33'd0, 1'b1}) begin n_fail++; $display("FAIL exp_zero: got %h/%b want 0/1", r, bus.unf); end
    pulse_clr();
  endtask

  task automatic test_overflow;
    logic [32:0] r; int lat;
    run_op(1'b0, 8'd254, 24'h800000, 1'b0, 8'd254, 24'h800000, r, lat);
    n_cmp++; if (r !== {1'b0, 8'd254, 24'hFFFFFF}) begin n_fail++; $display("FAIL overflow_result: got %h want %h", r, {1'b0, 8'd254, 24'hFFFFFF}); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL overflow_flag: got %b want 1", bus.ovf); end
    run_op(1'b0, 8'd254, 24'h800000, 1'b0, 8'd127, 24'h800000, r, lat);
    n_cmp++; if (r !== {1'b0, 8'd254, 24'h800000}) begin n_fail++; $display("FAIL emax_exact: got %h want %h", r, {1'b0, 8'd254, 24'h800000}); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b want 1", bus.ovf); end
    pulse_clr();
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b want 0", bus.ovf); end
    // Normalisation pushes 254 to 255; sign must survive saturation
    run_op(1'b1, 8'd254, 24'hC00000, 1'b0, 8'd127, 24'hC00000, r, lat);
    n_cmp++; if ({r, bus.ovf} !== {1'b1, 8'd254, 24'hFFFFFF, 1'b1}) begin n_fail++; $display("FAIL overflow_norm: got %h/%b want %h/1", r, bus.ovf, {1'b1, 8'd254, 24'hFFFFFF}); end
    pulse_clr();
    bus.flag_clr = 1'b1;
    run_op(1'b0, 8'd250, 24'h800000, 1'b0, 8'd250, 24'h800000, r, lat);
    n_cmp++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear: got %b want 1", bus.ovf); end
    @(posedge clk);
    #1;
    bus.flag_clr = 1'b0;
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL clear_after_set: got %b want 0", bus.ovf); end
  endtask

  task automatic test_back_to_back;
    logic [32:0] exp_r [5];
    logic [32:0] prev;
    int sent, got;
    sent = 0; got = 0; prev = '0;
    for (int k = 0; k < 5; k++) exp_r[k] = {k[0], 8'(120 + k), 24'hC00000};
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      bus.in_valid = (sent < 5);
      bus.as = 1'b0; bus.ae = 8'd127; bus.am = 24'hC00000;
      bus.bs = sent[0]; bus.be = 8'(120 + sent); bus.bm = 24'h800000;
      bus.out_ready = !(c >= 4 && c <= 7);
      #1;
      if (c >= 4 && c <= 7) begin
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c=%0d: got %b want 0", c, bus.in_ready); end
      end
      if (c >= 5 && c <= 7) begin
        n_cmp++; if ({bus.ps, bus.pe, bus.pm} !== prev) begin n_fail++; $display("FAIL stall_hold c=%0d: got %h want %h", c, {bus.ps, bus.pe, bus.pm}, prev); end
      end
      prev = {bus.ps, bus.pe, bus.pm};
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++; if (prev !== exp_r[got]) begin n_fail++; $display("FAIL stream_result %0d: got %h want %h", got, prev, exp_r[got]); end
        got++;
      end
    end
    n_cmp++; if (got !== 5) begin n_fail++; $display("FAIL stream_count: got %0d want 5", got); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_no_extra: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_midstream;
    int seen;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.as = 1'b0; bus.ae = 8'd127; bus.am = 24'hC00000;
      bus.bs = 1'b0; bus.be = 8'd127; bus.bm = 24'h800000;
    end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midstream_valid: got %b want 1", bus.out_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midstream_reset: got %b want 0", bus.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL midstream_flushed: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_simple();
    test_normalise();
    test_round_even();
    test_zero_underflow();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float_multiplier_pipe.md
Name: float_multiplier_pipe

Overview:
3-stage pipelined single-precision multiplier in the DCT datapath. It forms coefficient × sample products in unpacked format: sign, 8-bit biased exponent, and 24-bit mantissa with explicit hidden bit (mantissa 0 = zero). Its output feeds float_adder directly for DCT accumulation. Valid/ready handshake on both sides; whole-pipe stall on back-pressure.

Parameters:
BIAS, 127, exponent bias
EMAX, 254, largest legal output exponent; larger results saturate

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  pipe accepts operands this cycle
as  in  1  sign of A
ae  in  8  biased exponent of A
am  in  24  mantissa of A, bit23 = hidden 1, 0 = zero
bs  in  1  sign of B
be  in  8  biased exponent of B
bm  in  24  mantissa of B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
ps  out  1  product sign
pe  out  8  product biased exponent
pm  out  24  product mantissa, bit23 set unless zero
flag_clr  in  1  clears sticky flags
ovf  out  1  sticky: a result saturated
unf  out  1  sticky: a result flushed to zero

Behaviour:
- Reset: ps=0, pe=0, pm=0, out_valid=0, ovf=0, unf=0, all stage valids=0. Reset mid-stream discards all in-flight data.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational). Every stage register loads only when adv=1.
- Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
- Stage valids shift v1<-in_valid&in_ready, v2<-v1, out_valid<-v2 on adv. Latency: exactly 3 clk edges from accept to out_valid with no stall. Throughput: 1/clk.
- Stage 1: register sign = as^bs, zero = (am==0)|(bm==0), and 10-bit signed exp = ae+be-BIAS. Register the 48-bit product P = am*bm (full product allowed; a split 24x12 partial-product form is also permitted if summed by stage 2).
- Stage 2 normalise:
  - If P[47]: mant=P[47:24], G=P[23], R=P[22], S=|P[21:0], exp+=1.
  - Else: mant=P[46:23], G=P[22], R=P[21], S=|P[20:0].
- Stage 2 round to nearest even: increment when G&(R|S|mant[0]). If the increment carries out of bit23, mant=24'h800000 and exp+=1.
- Stage 3 range and zero:
  - zero → ps=0, pe=0, pm=0, no flag.
  - exp<1 → ps=0, pe=0, pm=0, unf set.
  - exp>EMAX → pe=EMAX, pm=24'hFFFFFF, sign kept, ovf set.
  - Otherwise pe=exp[7:0], pm=mant.
- Sticky flags: set on the cycle the offending result enters the output register. flag_clr clears them. If set and clear coincide, set wins.
- Exponent 255 inputs are not special (no inf/NaN), matching float_adder.
- Outputs stay stable while out_valid && !out_ready.

Test Plan:
- Simple product: A=(0,127,C00000), B=(0,128,800000), out_ready=1 → exactly 3 cycles later out_valid=1 and (0,128,C00000).
- Normalise shift: A=B=(1,127,C00000) → (0,128,900000). Signs cancel; P[47] path.
- Round-to-even tie: A=(0,127,800001), B=(0,127,C00000) → (0,127,C00002). Here G=1, R=0, S=0, lsb=1.
- Zero and underflow: am=0 with any B → (0,0,000000), no flag. A=(0,1,800000), B=(0,1,800000) → (0,0,000000), unf=1. flag_clr pulse → unf=0.
- Overflow: A=B=(0,254,800000) → (0,254,FFFFFF), ovf=1 and stays 1 until flag_clr.
- Back-pressure: stream 5 operand pairs with out_ready=0 for cycles 4-7 → in_ready=0 during stall; outputs held; all 5 results emerge in order, none lost or duplicated. Assert rst mid-stream → out_valid=0 next cycle.
